eggtimer_core: RTL and testbench
================================

Name: eggtimer_core

Overview:
- Countdown engine of the egg timer; the source side of the bar-graph display interface.
- Accepts debounced single-cycle button pulses to program a duration and to start, pause and acknowledge the timer.
- Drives prog_seconds (programmed duration) and timer_seconds (elapsed seconds, counting up 0..prog_seconds), both consumed by the bar-graph display.
- Raises a blinking alarm when elapsed time reaches the programmed time.

Parameters:
- TICK_DIV, 100000000, clk cycles per second (1 Hz tick period); sim uses 4.
- BLINK_DIV, 50000000, clk cycles per alarm half-period; sim uses 2.
- MIN_STEP, 60, seconds added per btn_min pulse.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_start  in  1  start/resume pulse (1 cycle, debounced upstream)
- btn_stop  in  1  pause/acknowledge pulse
- btn_clear  in  1  abort/clear pulse
- btn_sec  in  1  add 1 s to programmed time
- btn_min  in  1  add MIN_STEP s to programmed time
- prog_seconds  out  12  programmed duration, 0..4095
- timer_seconds  out  12  elapsed seconds, 0..prog_seconds
- running  out  1  high in RUN
- done  out  1  high in DONE
- alarm  out  1  blinks in DONE, 0 otherwise
- tick  out  1  1-cycle pulse on each counted second in RUN

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE; prog_seconds=0, timer_seconds=0, prescaler=0, blink counter=0; all 1-bit outputs=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered; every transition takes effect on the clock edge following the input pulse.
- Per-cycle priority: clear > stop > start > sec/min.
- IDLE:
  - btn_sec adds 1; btn_min adds MIN_STEP; both in the same cycle add MIN_STEP+1.
  - Additions saturate at 4095 (never wrap).
  - btn_clear sets prog_seconds=0.
  - btn_start with prog_seconds>0 → RUN, timer_seconds=0, prescaler=0.
  - btn_start with prog_seconds==0 is ignored. btn_stop is ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. At terminal count: prescaler→0, tick=1 for one cycle, timer_seconds+=1.
  - If the incremented value equals prog_seconds → DONE on the same edge.
  - sec/min and start are ignored; prog_seconds is frozen.
  - btn_stop → PAUSE with prescaler held. If stop coincides with the terminal count, the increment still occurs (and may enter DONE, which takes precedence over PAUSE).
  - btn_clear → IDLE, timer_seconds=0, prog_seconds retained, no tick.
- PAUSE:
  - Prescaler and timer_seconds hold.
  - btn_start → RUN, resuming the prescaler from its held value (no lost sub-second).
  - btn_clear → IDLE, timer_seconds=0. sec/min/stop are ignored.
- DONE:
  - timer_seconds==prog_seconds is held.
  - Blink counter runs; alarm toggles every BLINK_DIV cycles, first high BLINK_DIV cycles after entry (alarm=0 on entry).
  - btn_start, btn_stop or btn_clear → IDLE, timer_seconds=0, alarm=0, prog_seconds retained for a rerun.
- Invariant: timer_seconds <= prog_seconds at all times. 12-bit unsigned arithmetic; saturating add computed in 13 bits and clamped.
- running=(state==RUN); done=(state==DONE); tick=0 outside RUN.
- Reset mid-RUN/PAUSE/DONE: immediate return to the reset values above; prog_seconds is lost.

Decomposition:
- Shared header eggtimer_defs.vh holds:
  - state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3, 2 bits)
  - SEC_W=12 and SEC_MAX=4095
  - default MIN_STEP
- The bar-graph display uses SEC_W from the same header.
- One sub-module, tick_prescaler: parameter DIV; inputs clk, reset, clr, en; output pulse (1 cycle at terminal count, holds when en=0). Instantiated twice: 1 Hz tick (en=RUN) and alarm blink (en=DONE, clr on DONE entry).

Test Plan:
- Reset, then btn_min×2 + btn_sec×5 → prog_seconds=125, timer_seconds=0, state IDLE, no tick.
- Saturation: prog=4090, btn_min → prog=4095. btn_min and btn_sec in the same cycle at prog=4000 → 4061.
- TICK_DIV=4, prog=3, btn_start → tick every 4 cycles. timer_seconds 1,2,3; on the third tick edge done=1, running=0. With BLINK_DIV=2, alarm reads 0,0,1,1,0,0…; btn_stop → IDLE, timer=0, prog=3.
- Pause/resume: prog=5, start, stop 2 cycles after first tick (prescaler=2) → timer=1 held 10 cycles. Start → next tick 2 cycles later, timer=2.
- Stop coincident with terminal count at timer=1, prog=5 → timer=2, PAUSE. Same coincidence at timer=4 → DONE, not PAUSE.
- btn_start with prog=0 ignored. btn_clear mid-RUN at timer=2 → IDLE, timer=0, prog retained. Synchronous reset mid-RUN → all outputs 0 on the next edge.

Source files
------------

// File: rtl/eggtimer_pkg.sv
// Shared egg-timer definitions: state encodings, seconds width and the saturating adder.
package eggtimer_pkg;

    localparam int          SEC_W        = 12;
    localparam logic [11:0] SEC_MAX      = 12'd4095;
    localparam int unsigned MIN_STEP_DEF = 60;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Add in SEC_W+1 bits so a carry out clamps instead of wrapping.
    function automatic logic [SEC_W-1:0] sat_add(input logic [SEC_W-1:0] a,
                                                 input logic [SEC_W-1:0] b);
        logic [SEC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SEC_W] ? SEC_MAX : sum[SEC_W-1:0];
    endfunction

endpackage

// File: rtl/eggtimer_core_tick_prescaler.sv
// Free-running divider: pulse is high during the cycle the count sits at DIV-1 while enabled.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic pulse
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          terminal;

    assign terminal = (cnt_q == CW'(DIV - 1));
    assign pulse    = en && terminal;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = terminal ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/eggtimer_core.sv
// Egg-timer countdown engine: programs a duration, counts elapsed seconds up to it, then blinks the alarm.
module eggtimer_core
    import eggtimer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned BLINK_DIV = 50000000,
    parameter int unsigned MIN_STEP  = MIN_STEP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_clear,
    input  logic              btn_sec,
    input  logic              btn_min,
    output logic [SEC_W-1:0]  prog_seconds,
    output logic [SEC_W-1:0]  timer_seconds,
    output logic              running,
    output logic              done,
    output logic              alarm,
    output logic              tick
);

    logic [1:0]       state_q, state_d;
    logic [SEC_W-1:0] prog_q, prog_d;
    logic [SEC_W-1:0] timer_q, timer_d;
    logic             tick_q, tick_d;
    logic             alarm_q, alarm_d;

    logic             sec_pulse, blink_pulse, pre_clr;
    logic [SEC_W-1:0] step_add, nxt_timer;

    // Prescaler only keeps its phase across RUN/PAUSE; anything else restarts it.
    assign pre_clr = (state_q == ST_IDLE) || (state_q == ST_DONE) || btn_clear;

    tick_prescaler #(.DIV(TICK_DIV)) u_sec_div (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .en    (state_q == ST_RUN),
        .pulse (sec_pulse)
    );

    tick_prescaler #(.DIV(BLINK_DIV)) u_blink_div (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != ST_DONE),
        .en    (state_q == ST_DONE),
        .pulse (blink_pulse)
    );

    assign step_add  = (btn_sec ? SEC_W'(1) : '0) + (btn_min ? SEC_W'(MIN_STEP) : '0);
    assign nxt_timer = timer_q + SEC_W'(1);

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        timer_d = timer_q;
        tick_d  = 1'b0;
        alarm_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_clear)
                    prog_d = '0;
                else if (btn_stop)
                    prog_d = prog_q;
                else if (btn_start) begin
                    if (prog_q != '0) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                    end
                end else if (btn_sec || btn_min)
                    prog_d = sat_add(prog_q, step_add);
            end
            ST_RUN: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    // A second completing on the stop edge still counts; DONE beats PAUSE.
                    if (btn_stop)
                        state_d = ST_PAUSE;
                    if (sec_pulse) begin
                        tick_d  = 1'b1;
                        timer_d = nxt_timer;
                        if (nxt_timer == prog_q)
                            state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (!btn_stop && btn_start)
                    state_d = ST_RUN;
            end
            ST_DONE: begin
                if (btn_start || btn_stop || btn_clear) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else
                    alarm_d = alarm_q ^ blink_pulse;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prog_q  <= '0;
            timer_q <= '0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            timer_q <= timer_d;
            tick_q  <= tick_d;
            alarm_q <= alarm_d;
        end
    end

    assign prog_seconds  = prog_q;
    assign timer_seconds = timer_q;
    assign running       = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign alarm         = alarm_q;
    assign tick          = tick_q;

endmodule

// File: tb/tb_eggtimer_core.sv
// Directed bench for eggtimer_core with TICK_DIV=4, BLINK_DIV=2, MIN_STEP=60.
module tb_eggtimer_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start, btn_stop, btn_clear, btn_sec, btn_min;
    logic [11:0] prog_seconds, timer_seconds;
    logic        running, done, alarm, tick;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eggtimer_core #(.TICK_DIV(4), .BLINK_DIV(2), .MIN_STEP(60)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_start     (btn_start),
        .btn_stop      (btn_stop),
        .btn_clear     (btn_clear),
        .btn_sec       (btn_sec),
        .btn_min       (btn_min),
        .prog_seconds  (prog_seconds),
        .timer_seconds (timer_seconds),
        .running       (running),
        .done          (done),
        .alarm         (alarm),
        .tick          (tick)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask bits: {start, stop, clear, sec, min}
    task automatic press(input logic [4:0] mask);
        {btn_start, btn_stop, btn_clear, btn_sec, btn_min} = mask;
        step(1);
        {btn_start, btn_stop, btn_clear, btn_sec, btn_min} = '0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    localparam logic [4:0] B_START = 5'b10000;
    localparam logic [4:0] B_STOP  = 5'b01000;
    localparam logic [4:0] B_CLEAR = 5'b00100;
    localparam logic [4:0] B_SEC   = 5'b00010;
    localparam logic [4:0] B_MIN   = 5'b00001;

    initial begin
        reset = 1'b1;
        {btn_start, btn_stop, btn_clear, btn_sec, btn_min} = '0;
        step(2);
        reset = 1'b0;
        chk("rst_prog", prog_seconds, 0);
        chk("rst_timer", timer_seconds, 0);
        chk("rst_flags", {running, done, alarm, tick}, 0);

        // Programming
        press(B_MIN); press(B_MIN);
        for (int i = 0; i < 5; i++) press(B_SEC);
        chk("prog_125", prog_seconds, 125);
        chk("prog_timer0", timer_seconds, 0);
        chk("prog_idle", {running, done, tick}, 0);

        // Saturation
        press(B_CLEAR);
        chk("clear_prog", prog_seconds, 0);
        for (int i = 0; i < 68; i++) press(B_MIN);
        for (int i = 0; i < 10; i++) press(B_SEC);
        chk("prog_4090", prog_seconds, 4090);
        press(B_MIN);
        chk("sat_4095", prog_seconds, 4095);
        press(B_MIN | B_SEC);
        chk("sat_hold", prog_seconds, 4095);
        press(B_CLEAR);
        for (int i = 0; i < 66; i++) press(B_MIN);
        for (int i = 0; i < 40; i++) press(B_SEC);
        chk("prog_4000", prog_seconds, 4000);
        press(B_MIN | B_SEC);
        chk("both_4061", prog_seconds, 4061);

        // Full run to DONE with prog=3
        press(B_CLEAR);
        for (int i = 0; i < 3; i++) press(B_SEC);
        press(B_START);
        chk("run_start", {running, done}, 2'b10);
        chk("run_t0", timer_seconds, 0);
        step(3);
        chk("run_notick", tick, 0);
        step(1);
        chk("run_tick1", tick, 1);
        chk("run_t1", timer_seconds, 1);
        step(1);
        chk("run_tick_low", tick, 0);
        step(3);
        chk("run_t2", timer_seconds, 2);
        step(4);
        chk("done_t3", timer_seconds, 3);
        chk("done_flags", {running, done, tick}, 3'b011);
        chk("alarm_0a", alarm, 0);
        step(1); chk("alarm_0b", alarm, 0);
        chk("done_tick_low", tick, 0);
        step(1); chk("alarm_1a", alarm, 1);
        step(1); chk("alarm_1b", alarm, 1);
        step(1); chk("alarm_0c", alarm, 0);
        step(1); chk("alarm_0d", alarm, 0);
        step(1); chk("alarm_1c", alarm, 1);
        chk("done_hold", timer_seconds, 3);
        press(B_STOP);
        chk("ack_flags", {running, done, alarm}, 0);
        chk("ack_timer", timer_seconds, 0);
        chk("ack_prog", prog_seconds, 3);

        // Pause / resume keeps the sub-second phase
        press(B_CLEAR);
        for (int i = 0; i < 5; i++) press(B_SEC);
        press(B_START);
        step(4);
        chk("pr_t1", timer_seconds, 1);
        step(1);
        press(B_STOP);
        chk("pr_paused", {running, done}, 0);
        step(10);
        chk("pr_hold_t", timer_seconds, 1);
        chk("pr_hold_tick", tick, 0);
        press(B_START);
        chk("pr_resume", running, 1);
        step(1);
        chk("pr_notick", tick, 0);
        step(1);
        chk("pr_tick", tick, 1);
        chk("pr_t2", timer_seconds, 2);

        // Stop coincident with the terminal count
        press(B_CLEAR);
        chk("clr_run_prog", prog_seconds, 5);
        press(B_START);
        step(4);
        step(3);
        press(B_STOP);
        chk("co_t2", timer_seconds, 2);
        chk("co_pause", {running, done, tick}, 3'b001);
        press(B_START);
        step(4); step(4);
        chk("co_t4", timer_seconds, 4);
        step(3);
        press(B_STOP);
        chk("co_t5", timer_seconds, 5);
        chk("co_done", {running, done}, 2'b01);
        press(B_START);
        chk("done_to_idle", {running, done}, 0);
        chk("done_to_idle_t", timer_seconds, 0);
        chk("done_to_idle_p", prog_seconds, 5);

        // Start with prog=0 is ignored
        press(B_CLEAR);
        press(B_START);
        chk("zero_start", {running, done}, 0);

        // Clear mid-RUN, coincident with a terminal count
        for (int i = 0; i < 5; i++) press(B_SEC);
        press(B_START);
        step(8);
        chk("cl_t2", timer_seconds, 2);
        step(3);
        press(B_CLEAR);
        chk("cl_idle", {running, done, tick}, 0);
        chk("cl_timer", timer_seconds, 0);
        chk("cl_prog", prog_seconds, 5);

        // Synchronous reset mid-RUN
        press(B_START);
        step(5);
        chk("rr_t1", timer_seconds, 1);
        reset = 1'b1;
        step(1);
        chk("rr_prog", prog_seconds, 0);
        chk("rr_timer", timer_seconds, 0);
        chk("rr_flags", {running, done, alarm, tick}, 0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
